// File: rtl/video_pkg.sv
// Shared video timing defaults, pixel/control types and swap FSM states.
package video_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_ADDR_W    = 20;
  localparam int DEF_RD_LAT    = 2;
  localparam int DEF_BUF1_BASE = 307200;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } pixel6;

  // Per-pixel control bits carried alongside the BRAM read latency.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_t;

endpackage

// File: rtl/video_timing.sv
// VGA raster counters with raw (undelayed) sync, active and frame strobes.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic first_px,
  output logic last_px,
  output logic eof
);

  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST  = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(VT - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  // Advance the raster position once per pixel-clock enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign active    = (h < H_ACT) && (v < V_ACT);
  assign hsync_raw = !((h >= HS_BEG) && (h < HS_END));
  assign vsync_raw = !((v >= VS_BEG) && (v < VS_END));
  assign first_px  = (h == '0) && (v == '0);
  assign last_px   = (h == H_ACT - 1'b1) && (v == V_ACT - 1'b1);
  assign eof       = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: linear read addressing, double-buffer swap,
// latency-matched control path and 6-to-12-bit colour expansion.
module fb_scanout
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int BUF1_BASE = DEF_BUF1_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [5:0]        rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_buf,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(BUF1_BASE);
  localparam ctl_t              CTL_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic active, hs_raw, vs_raw, first_px, last_px, eof;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .active    (active),
    .hsync_raw (hs_raw),
    .vsync_raw (vs_raw),
    .first_px  (first_px),
    .last_px   (last_px),
    .eof       (eof)
  );

  swap_state_t state;
  logic        blocked;
  logic        req_ok;
  logic        take_swap;
  logic        next_front;

  // A request is only honoured once it has dropped after the previous ack.
  assign req_ok     = swap_req && !blocked;
  assign take_swap  = en && eof && ((state == PENDING) || req_ok);
  assign next_front = front_buf ^ take_swap;

  // Swap handshake: latch the request, perform it on the end-of-frame cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      front_buf <= 1'b0;
      swap_ack  <= 1'b0;
      blocked   <= 1'b0;
    end else begin
      swap_ack <= take_swap;
      if (take_swap) begin
        front_buf <= ~front_buf;
        state     <= IDLE;
        blocked   <= 1'b1;
      end else begin
        if (!swap_req) blocked <= 1'b0;
        if (en && (state == IDLE) && req_ok) state <= PENDING;
      end
    end
  end

  // Linear read address. It parks on the buffer base once the last visible
  // pixel has been fetched, and is reloaded at end of frame with the base
  // of whichever buffer will be displayed next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (en) begin
      if (eof)          rd_addr <= next_front ? BASE1 : '0;
      else if (last_px) rd_addr <= front_buf ? BASE1 : '0;
      else if (active)  rd_addr <= rd_addr + 1'b1;
    end
  end

  ctl_t dly [RD_LAT];

  // Delay control bits by the BRAM read latency so they line up with rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) dly[i] <= CTL_IDLE;
    end else if (en) begin
      dly[0] <= '{de: active, hs: hs_raw, vs: vs_raw, fs: first_px};
      for (int unsigned i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  ctl_t  tail;
  pixel6 pix;
  assign tail = dly[RD_LAT-1];
  assign pix  = rd_data;

  // Output register: syncs, enables and colour expanded by bit replication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (en) begin
      de          <= tail.de;
      hsync       <= tail.hs;
      vsync       <= tail.vs;
      frame_start <= tail.fs;
      vga_r       <= tail.de ? {pix.r, pix.r} : '0;
      vga_g       <= tail.de ? {pix.g, pix.g} : '0;
      vga_b       <= tail.de ? {pix.b, pix.b} : '0;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout on a reduced raster, with a BRAM model
// and an arithmetic reference of the expected scan.
module tb_fb_scanout;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int BUF1 = 128;
  localparam int AW = 20;

  typedef struct packed {
    logic de, hs, vs, fs;
    logic [3:0] r, g, b;
  } out_t;

  localparam out_t RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};

  logic          clk, rst_n, en, swap_req;
  logic [AW-1:0] rd_addr;
  logic [5:0]    rd_data;
  logic          swap_ack, front_buf, hsync, vsync, de, frame_start;
  logic [3:0]    vga_r, vga_g, vga_b;

  fb_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .ADDR_W (AW), .RD_LAT (2), .BUF1_BASE (BUF1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .rd_addr (rd_addr), .rd_data (rd_data),
    .swap_req (swap_req), .swap_ack (swap_ack), .front_buf (front_buf),
    .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
    .hsync (hsync), .vsync (vsync), .de (de), .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model with a two en-cycle read latency.
  logic [5:0] mem [256];
  logic [5:0] p1, p2;
  always_ff @(posedge clk) begin
    if (en) begin
      p1 <= mem[rd_addr[7:0]];
      p2 <= p1;
    end
  end
  assign rd_data = p2;

  int   n_cmp = 0, n_bad = 0;
  int   t;
  bit   fb, pending, blocked, ack_e;
  out_t q[$];
  out_t exp_o;
  int   exp_addr;

  // Ideal outputs for raster position pos of a frame shown from buffer fbv.
  function automatic out_t f_out(input int pos, input bit fbv);
    out_t o;
    int h, v;
    logic [5:0] p;
    h = pos % HT;
    v = pos / HT;
    o = RST;
    o.de = (h < HA) && (v < VA);
    o.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    o.vs = !((v >= VA + VF) && (v < VA + VF + VS));
    o.fs = (pos == 0);
    if (o.de) begin
      p = mem[(fbv ? BUF1 : 0) + v * HA + h];
      o.r = {p[5:4], p[5:4]};
      o.g = {p[3:2], p[3:2]};
      o.b = {p[1:0], p[1:0]};
    end
    return o;
  endfunction

  // Read address at position pos: base plus visible pixels already fetched,
  // wrapping to the base once the whole visible area has been read.
  function automatic int f_addr(input int pos, input bit fbv);
    int h, v, n;
    h = pos % HT;
    v = pos / HT;
    n = (v < VA) ? v * HA + ((h < HA) ? h : HA) : HA * VA;
    if (n == HA * VA) n = 0;
    return (fbv ? BUF1 : 0) + n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, expv, t);
    end
  endtask

  task automatic chk_reset();
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_front", front_buf, 0);
    chk("rst_ack", swap_ack, 0);
  endtask

  task automatic model_reset();
    t = 0; fb = 0; pending = 0; blocked = 0; ack_e = 0;
    q.delete();
    q.push_back(f_out(0, 1'b0));
    exp_o = RST;
    exp_addr = 0;
  endtask

  // One clock: update the reference from the inputs seen at the edge, then check.
  task automatic step();
    bit en_s, req_s;
    @(posedge clk);
    en_s  = en;
    req_s = swap_req;
    ack_e = 0;
    if (en_s) begin
      if ((t % FR == FR - 1) && (pending || (req_s && !blocked))) begin
        fb = ~fb;
        ack_e = 1;
        pending = 0;
      end else if (req_s && !blocked) begin
        pending = 1;
      end
      t++;
      q.push_back(f_out(t % FR, fb));
      if (q.size() > 4) void'(q.pop_front());
      if (q.size() == 4) exp_o = q[0];
      exp_addr = f_addr(t % FR, fb);
    end
    if (ack_e) blocked = 1;
    else if (!req_s) blocked = 0;
    #1;
    chk("rd_addr", rd_addr, exp_addr);
    chk("swap_ack", swap_ack, ack_e);
    chk("front_buf", front_buf, fb);
    chk("de", de, exp_o.de);
    chk("hsync", hsync, exp_o.hs);
    chk("vsync", vsync, exp_o.vs);
    chk("frame_start", frame_start, exp_o.fs);
    chk("vga_r", vga_r, exp_o.r);
    chk("vga_g", vga_g, exp_o.g);
    chk("vga_b", vga_b, exp_o.b);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 6'($urandom);
    mem[0] = 6'b110110;
    rst_n = 1'b0; en = 1'b1; swap_req = 1'b0;

    // Reset held for five clocks
    repeat (5) begin
      @(posedge clk); #1;
      chk_reset();
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // First pixels: address ramp and colour of mem[0] after three clocks
    step(); chk("addr_1", rd_addr, 1);
    step(); chk("addr_2", rd_addr, 2);
    step();
    chk("first_de", de, 1);
    chk("first_fs", frame_start, 1);
    chk("first_r", vga_r, 4'hF);
    chk("first_g", vga_g, 4'h5);
    chk("first_b", vga_b, 4'hA);

    // Two full frames at full rate
    repeat (2 * FR) step();

    // Mid-frame swap request, held 10 clocks past the ack
    for (int i = 0; i < 2 * FR && (t % FR) != 3 * HT + 5; i++) step();
    swap_req = 1'b1;
    for (int i = 0; i < 2 * FR && !ack_e; i++) step();
    chk("swap1_ack", swap_ack, 1);
    chk("swap1_front", front_buf, 1);
    chk("swap1_addr", rd_addr, BUF1);
    repeat (10) step();
    swap_req = 1'b0;
    repeat (2 * FR) step();

    // Request raised exactly on the end-of-frame cycle
    for (int i = 0; i < 2 * FR && (t % FR) != FR - 1; i++) step();
    swap_req = 1'b1;
    step();
    chk("swap2_ack", swap_ack, 1);
    chk("swap2_front", front_buf, 0);
    chk("swap2_addr", rd_addr, 0);
    step();
    swap_req = 1'b0;
    repeat (FR) step();

    // Half-rate enable
    for (int i = 0; i < 2 * FR; i++) begin
      en = (i % 2 == 0);
      step();
    end

    // Random enable and renderer requests
    for (int i = 0; i < 3 * FR; i++) begin
      en = ($urandom_range(3) != 0);
      if (!swap_req && $urandom_range(150) == 0) swap_req = 1'b1;
      else if (ack_e && $urandom_range(1) == 0) swap_req = 1'b0;
      else if (swap_req && !pending && blocked && $urandom_range(3) == 0) swap_req = 1'b0;
      step();
    end
    swap_req = 1'b0;
    en = 1'b1;
    repeat (3) step();

    // Ensure buffer 1 is displayed, leave a request pending, then reset mid-frame
    if (!fb) begin
      swap_req = 1'b1;
      for (int i = 0; i < 2 * FR && !ack_e; i++) step();
      chk("swap3_ack", swap_ack, 1);
      step();
      swap_req = 1'b0;
    end
    for (int i = 0; i < 2 * FR && (t % FR) != 5 * HT + 7; i++) step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    #1 chk_reset();
    @(posedge clk); #1 chk_reset();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (FR + 10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
